// File: rtl/sys_bridge_timer_if.sv
// Data-bus bundle between the CPU MEM stage, this bridge and the external data memory.
// The master side is the CPU plus DM; the slave side is the bridge.
interface sys_bridge_timer_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_byteen, dm_rdata,
        input  cpu_rdata, dm_addr, dm_wdata, dm_byteen
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_byteen, dm_rdata,
        output cpu_rdata, dm_addr, dm_wdata, dm_byteen
    );
endinterface

// File: rtl/sys_bridge_timer.sv
// MEM-stage bridge: routes the CPU data bus to DM or to countdown timer(s), builds HWInt.
// Define SYS_BRIDGE_TIMER1_EN to add a second timer at TIMER_BASE+16 driving hw_int[1].
module sys_bridge_timer #(
    parameter logic [31:0] DM_END     = 32'h0000_2FFF,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    sys_bridge_timer_if.slave bus,
    input  logic              ext_int,
    output logic [5:0]        hw_int
);

`ifdef SYS_BRIDGE_TIMER1_EN
    localparam int NT = 2;
`else
    localparam int NT = 1;
`endif

    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_CNT, T_INT} tstate_e;

    logic          r_ctrl   [NT];
    logic [31:0]   r_preset [NT];
    logic [31:0]   r_count  [NT];
    tstate_e       r_state  [NT];
    logic          r_irq    [NT];
    logic [3:0]    r_ctrl_q [NT];

    logic [3:0]    w_ctrl_nxt   [NT];
    logic [3:0]    w_ctrl_eff   [NT];
    logic [31:0]   w_preset_nxt [NT];
    logic [31:0]   w_count_nxt  [NT];
    tstate_e       w_state_nxt  [NT];
    logic          w_irq_nxt    [NT];
    logic          w_hit_t      [NT];
    logic          w_ctrl_wr    [NT];
    logic          w_pre_wr     [NT];

    logic          w_hit_dm;
    logic          w_wr_full;
    logic [1:0]    w_idx;

    // r_ctrl mirrors CTRL.EN for readability of the FSM; r_ctrl_q holds all four CTRL bits.
    always_comb begin
        for (int k = 0; k < NT; k++) r_ctrl[k] = r_ctrl_q[k][0];
    end

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        w_hit_dm  = (bus.cpu_addr <= DM_END);
        w_wr_full = (bus.cpu_byteen == 4'b1111);
        w_idx     = bus.cpu_addr[3:2];
        for (int k = 0; k < NT; k++) begin
            w_hit_t[k] = (bus.cpu_addr >= TIMER_BASE + 32'(16 * k)) &&
                         (bus.cpu_addr <= TIMER_BASE + 32'(16 * k + 11));
        end
    end

    assign bus.dm_addr   = bus.cpu_addr;
    assign bus.dm_wdata  = bus.cpu_wdata;
    assign bus.dm_byteen = w_hit_dm ? bus.cpu_byteen : 4'b0000;

    // Next-state logic; a CTRL write in the same cycle is seen as the live EN so the
    // IDLE->LOAD step happens on the write edge itself.
    always_comb begin
        for (int k = 0; k < NT; k++) begin
            w_ctrl_wr[k]    = w_hit_t[k] && w_wr_full && (w_idx == 2'd0);
            w_pre_wr[k]     = w_hit_t[k] && w_wr_full && (w_idx == 2'd1);
            w_ctrl_eff[k]   = w_ctrl_wr[k] ? bus.cpu_wdata[3:0] : r_ctrl_q[k];
            w_ctrl_nxt[k]   = w_ctrl_eff[k];
            w_preset_nxt[k] = w_pre_wr[k] ? bus.cpu_wdata : r_preset[k];
            w_count_nxt[k]  = r_count[k];
            w_state_nxt[k]  = r_state[k];
            w_irq_nxt[k]    = r_irq[k];

            unique case (r_state[k])
                T_IDLE: begin
                    if (w_ctrl_eff[k][0]) w_state_nxt[k] = T_LOAD;
                end
                T_LOAD: begin
                    w_count_nxt[k] = r_preset[k];
                    w_state_nxt[k] = T_CNT;
                end
                T_CNT: begin
                    if (!w_ctrl_eff[k][0]) begin
                        w_state_nxt[k] = T_IDLE;
                    end else if (r_count[k] == 32'd0) begin
                        w_state_nxt[k] = T_INT;
                        w_irq_nxt[k]   = 1'b1;
                    end else begin
                        w_count_nxt[k] = r_count[k] - 32'd1;
                    end
                end
                T_INT: begin
                    if (r_ctrl_q[k][2:1] == 2'b01) begin
                        w_irq_nxt[k]   = 1'b0;
                        w_state_nxt[k] = T_LOAD;
                    end else begin
                        if (!w_ctrl_wr[k]) w_ctrl_nxt[k][0] = 1'b0;
                        w_state_nxt[k] = T_IDLE;
                    end
                end
                default: w_state_nxt[k] = T_IDLE;
            endcase

            // An accepted CTRL write always wins over a flag set in the same cycle.
            if (w_ctrl_wr[k]) w_irq_nxt[k] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NT; k++) begin
                r_ctrl_q[k] <= 4'b0;
                r_preset[k] <= 32'd0;
                r_count[k]  <= 32'd0;
                r_state[k]  <= T_IDLE;
                r_irq[k]    <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NT; k++) begin
                r_ctrl_q[k] <= w_ctrl_nxt[k];
                r_preset[k] <= w_preset_nxt[k];
                r_count[k]  <= w_count_nxt[k];
                r_state[k]  <= w_state_nxt[k];
                r_irq[k]    <= w_irq_nxt[k];
            end
        end
    end

    always_comb begin
        bus.cpu_rdata = 32'h0;
        if (w_hit_dm) begin
            bus.cpu_rdata = bus.dm_rdata;
        end else begin
            for (int k = 0; k < NT; k++) begin
                if (w_hit_t[k]) begin
                    unique case (w_idx)
                        2'd0:    bus.cpu_rdata = {28'd0, r_ctrl_q[k]};
                        2'd1:    bus.cpu_rdata = r_preset[k];
                        2'd2:    bus.cpu_rdata = r_count[k];
                        default: bus.cpu_rdata = 32'h0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        hw_int = 6'b0;
        for (int k = 0; k < NT; k++) hw_int[k] = r_irq[k] & r_ctrl_q[k][3];
        hw_int[2] = ext_int;
    end

endmodule

// File: tb/tb_sys_bridge_timer.sv
// Scoreboard bench for sys_bridge_timer: expectations are queued as stimulus is driven
// and popped when the DUT response is sampled, 1 ns after each rising edge.
module tb_sys_bridge_timer;

    localparam logic [31:0] A_CTRL0 = 32'h0000_7F00;
    localparam logic [31:0] A_PRE0  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT0  = 32'h0000_7F08;
    localparam logic [31:0] A_CTRL1 = 32'h0000_7F10;
    localparam logic [31:0] A_PRE1  = 32'h0000_7F14;
    localparam logic [31:0] DM_KEY  = 32'hDEAD_BEEF;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_int;
    logic [5:0] hw_int;

    sys_bridge_timer_if u_if ();

    sys_bridge_timer u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (u_if),
        .ext_int (ext_int),
        .hw_int  (hw_int)
    );

    always #5 clk = ~clk;

    // DM model: combinational read data derived from the address.
    assign u_if.dm_rdata = u_if.dm_addr ^ DM_KEY;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        u_if.cpu_addr   = addr;
        u_if.cpu_wdata  = data;
        u_if.cpu_byteen = be;
        cyc();
        u_if.cpu_byteen = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        u_if.cpu_addr   = addr;
        u_if.cpu_byteen = 4'b0000;
        push(tag, exp);
        #1;
        observe(u_if.cpu_rdata);
    endtask

    task automatic chk_hw(input string tag, input logic [5:0] exp);
        push(tag, {26'd0, exp});
        observe({26'd0, hw_int});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        reset           = 1'b0;
        ext_int         = 1'b0;
        u_if.cpu_addr   = 32'h0;
        u_if.cpu_wdata  = 32'h0;
        u_if.cpu_byteen = 4'b0000;
        repeat (2) cyc();
        reset = 1'b1;

        rd("rst_ctrl", A_CTRL0, 32'h0);
        rd("rst_count", A_CNT0, 32'h0);
        chk_hw("rst_hw", 6'b0);

        // Reset in the middle of a count
        wr(A_PRE0, 32'd10, 4'b1111);
        wr(A_CTRL0, 32'h9, 4'b1111);
        repeat (6) cyc();
        rd("mid_count5", A_CNT0, 32'd5);
        reset = 1'b0;
        rd("arst_ctrl", A_CTRL0, 32'h0);
        rd("arst_preset", A_PRE0, 32'h0);
        rd("arst_count", A_CNT0, 32'h0);
        chk_hw("arst_hw", 6'b0);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();
        rd("post_rst_idle_count", A_CNT0, 32'h0);
        chk_hw("post_rst_hw", 6'b0);

        // Routing
        u_if.cpu_addr   = 32'h0000_0010;
        u_if.cpu_wdata  = 32'h1234_5678;
        u_if.cpu_byteen = 4'b0011;
        push("dm_byteen_hit", 32'h3);
        #1 observe({28'd0, u_if.dm_byteen});
        push("dm_addr", 32'h0000_0010);
        observe(u_if.dm_addr);
        push("dm_wdata", 32'h1234_5678);
        observe(u_if.dm_wdata);
        u_if.cpu_byteen = 4'b0000;
        u_if.cpu_addr   = A_PRE0;
        u_if.cpu_byteen = 4'b0001;
        push("dm_byteen_timer", 32'h0);
        #1 observe({28'd0, u_if.dm_byteen});
        cyc();
        u_if.cpu_byteen = 4'b0000;
        rd("partial_preset_dropped", A_PRE0, 32'h0);
        rd("oom_read", 32'h0000_4000, 32'h0);
        rd("dm_end_plus1", 32'h0000_3000, 32'h0);
        rd("dm_read", 32'h0000_0100, 32'h0000_0100 ^ DM_KEY);
        rd("dm_end_read", 32'h0000_2FFF, 32'h0000_2FFF ^ DM_KEY);
        rd("timer_idx3", 32'h0000_7F0C, 32'h0);
        wr(A_CTRL0, 32'h9, 4'b0001);
        rd("partial_ctrl_dropped", A_CTRL0, 32'h0);

        // One-shot, PRESET=3
        wr(A_PRE0, 32'd3, 4'b1111);
        rd("preset_rb", A_PRE0, 32'd3);
        wr(A_CTRL0, 32'h9, 4'b1111);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk_hw($sformatf("os_hw_c%0d", c), (c == 5) ? 6'b000001 : 6'b0);
            if (c == 1) rd("os_count_load", A_CNT0, 32'd3);
        end
        cyc();
        rd("os_en_cleared", A_CTRL0, 32'h8);
        chk_hw("os_hw_held", 6'b000001);
        repeat (3) cyc();
        chk_hw("os_hw_still", 6'b000001);
        wr(A_CTRL0, 32'h8, 4'b1111);
        chk_hw("os_hw_cleared", 6'b0);

        // Auto-reload, PRESET=2
        wr(A_PRE0, 32'd2, 4'b1111);
        wr(A_CTRL0, 32'hB, 4'b1111);
        for (int c = 1; c <= 11; c++) begin
            cyc();
            p = (c - 1) % 5;
            chk_hw($sformatf("ar_hw_c%0d", c), (p == 3) ? 6'b000001 : 6'b0);
            rd($sformatf("ar_count_c%0d", c), A_CNT0, (p <= 2) ? 32'(2 - p) : 32'd0);
        end
        wr(A_CTRL0, 32'h0, 4'b1111);
        repeat (4) cyc();

        // Masked, PRESET=0
        wr(A_PRE0, 32'd0, 4'b1111);
        wr(A_CTRL0, 32'h1, 4'b1111);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk_hw($sformatf("mask_hw_c%0d", c), 6'b0);
        end
        rd("mask_oneshot_done", A_CTRL0, 32'h0);
        wr(A_CNT0, 32'd7, 4'b1111);
        rd("count_ro", A_CNT0, 32'd0);
        ext_int = 1'b1;
        #1 chk_hw("ext_int", 6'b000100);
        ext_int = 1'b0;
        #1 chk_hw("ext_int_low", 6'b0);

`ifdef SYS_BRIDGE_TIMER1_EN
        wr(A_PRE1, 32'd1, 4'b1111);
        wr(A_CTRL1, 32'h9, 4'b1111);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk_hw($sformatf("t1_hw_c%0d", c), (c == 3) ? 6'b000010 : 6'b0);
        end
        rd("t0_untouched", A_CTRL0, 32'h0);
`else
        rd("t1_absent_read", A_CTRL1, 32'h0);
        wr(A_PRE1, 32'd1, 4'b1111);
        wr(A_CTRL1, 32'h9, 4'b1111);
        repeat (4) cyc();
        chk_hw("t1_absent_hw", 6'b0);
        rd("t1_absent_preset", A_PRE1, 32'h0);
`endif

        if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_bridge_timer.md
Name: sys_bridge_timer

Overview:
- Downstream neighbour of the pipelined CPU's MEM-stage data bus. It takes the CPU's address, write data and byte enables, routes them to data memory or to an on-block countdown timer, and returns the read data to the CPU as MemOut.
- It also builds the CPU's 6-bit HWInt vector from the timer interrupt and one external interrupt line.
- It sits between the CPU core, the external DM, and the top-level interrupt inputs.

Parameters:
- DM_END, 32'h0000_2FFF, last byte address of the data-memory window (window starts at 0).
- TIMER_BASE, 32'h0000_7F00, base address of timer 0 registers (12-byte window).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- cpu_addr  in  32  byte address from the CPU data bus (DM_addr).
- cpu_wdata  in  32  store data, already byte-lane aligned (MemData).
- cpu_byteen  in  4  store byte enables; a non-zero value means write.
- cpu_rdata  out  32  read data to the CPU (MemOut).
- dm_addr  out  32  address to DM.
- dm_wdata  out  32  write data to DM.
- dm_byteen  out  4  DM byte enables.
- dm_rdata  in  32  DM read data (combinational).
- ext_int  in  1  external interrupt level.
- hw_int  out  6  interrupt vector to the CPU (HWInt).

Behaviour:
- Decode (combinational):
  - hit_dm = cpu_addr <= DM_END.
  - hit_t0 = cpu_addr in [TIMER_BASE, TIMER_BASE+11].
  - Register index = cpu_addr[3:2].
- DM path:
  - dm_addr = cpu_addr and dm_wdata = cpu_wdata.
  - dm_byteen = hit_dm ? cpu_byteen : 4'b0000.
- Read mux (combinational):
  - hit_dm → dm_rdata.
  - hit_t0 → selected timer register.
  - Otherwise 32'h0.
- Timer registers:
  - CTRL at +0, read/write. Bit0 EN; bits[2:1] MODE (00 one-shot, 01 auto-reload, others treated as 00); bit3 IM (interrupt mask, 1 = enabled). Bits[31:4] read 0.
  - PRESET at +4, read/write, 32 bits.
  - COUNT at +8, read-only; writes to it are ignored.
  - Index 3 reads 0.
- Timer write: accepted only when hit_t0 and cpu_byteen==4'b1111. Partial-byte writes to the timer are dropped.
- Timer state machine, state register tstate:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT ← PRESET; go to CNT.
  - CNT:
    - If EN==0 → IDLE, COUNT holds.
    - Else if COUNT==0 → INT and set irq_flag.
    - Else COUNT ← COUNT−1.
  - INT, MODE 00: clear CTRL.EN, go to IDLE, irq_flag held.
  - INT, MODE 01: clear irq_flag, go to LOAD.
- irq_flag clearing:
  - Cleared by any accepted CTRL write.
  - A CTRL write and the flag set in the same cycle resolve as the write winning (flag cleared).
- Write/state priority: a CTRL write in the same cycle as an INT-state EN clear leaves CTRL holding the written value.
- PRESET writes never disturb a running COUNT; they take effect at the next LOAD.
- Timing: with PRESET=N, EN write at edge e gives state LOAD after e, COUNT=N after e+1, COUNT=0 after e+N+1, and irq_flag high after e+N+2.
- Interrupt vector:
  - hw_int[0] = irq_flag & CTRL.IM.
  - hw_int[2] = ext_int.
  - All other bits 0.
- Reset values: CTRL=0, PRESET=0, COUNT=0, tstate=IDLE, irq_flag=0, hw_int=6'b0. cpu_rdata and dm_* follow their inputs combinationally.
- Reset asserted mid-count aborts the count immediately, regardless of clk.
- Out-of-map accesses: writes are dropped, reads return 0. No exception is raised here; address exceptions belong to the CPU.

Optional Feature:
- Macro: SYS_BRIDGE_TIMER1_EN.
- Defined: adds a second, identical timer at TIMER_BASE+16 (window +16..+27) driving hw_int[1], with its own CTRL, PRESET, COUNT, state machine and flag.
- Undefined: the +16..+27 window is out-of-map (reads 0, writes dropped) and hw_int[1]=0.

Test Plan:
- Reset low while timer counting with COUNT=5 → CTRL, PRESET, COUNT and hw_int read 0 immediately; after release, state is IDLE.
- Routing:
  - Store to addr 0x0000_0010, byteen 4'b0011 → dm_byteen=4'b0011.
  - Store to 0x0000_7F04, byteen 4'b0001 → dm_byteen=0 and PRESET unchanged.
  - Read of 0x0000_4000 → cpu_rdata=0.
- One-shot: write PRESET=3, then CTRL=0x9 → hw_int[0] rises exactly 5 cycles after the CTRL write edge. CTRL.EN then reads 0 and hw_int[0] stays 1 until CTRL is written with 0x8, which drops hw_int[0] on the next edge.
- Auto-reload: PRESET=2, CTRL=0xB → hw_int[0] is a 1-cycle pulse every 5 cycles, with COUNT reading the sequence 2,1,0 then reloading.
- Masking and preset edge cases:
  - CTRL=0x1 (IM=0) with PRESET=0 → irq_flag sets 2 cycles after the write but hw_int[0] stays 0.
  - Writing COUNT=7 has no effect.
  - ext_int=1 → hw_int=6'b000100.
- With SYS_BRIDGE_TIMER1_EN defined: timer 1 at 0x7F10 with PRESET=1 and CTRL=0x9 → hw_int[1] pulses high after 3 cycles, independent of timer 0. Without the macro, a read of 0x7F10 returns 0.
